// File: rtl/data_mem_arb_pkg.sv
// Shared types for the data memory arbiter: channel FSM states and id sizing.
package data_mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        READ_WAIT   = 3'd1,
        WRITE_WAIT  = 3'd2,
        READ_RELAY  = 3'd3,
        WRITE_RELAY = 3'd4
    } channel_state_t;

    // Consumer-id width for the default 8-requester build.
    localparam int NUM_CONSUMERS_DEF = 8;
    localparam int CID_BITS          = $clog2(NUM_CONSUMERS_DEF);

    // Id width for any requester count; a single requester still needs one bit.
    function automatic int id_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_channel.sv
// One memory channel: claim FSM plus the consumer id, address and data latched at claim.
module mem_arb_channel
    import data_mem_arb_pkg::*;
#(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 8,
    parameter int CW           = 3,
    parameter int WRITE_ENABLE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 grant,
    input  logic                 grant_write,
    input  logic [CW-1:0]        grant_id,
    input  logic [ADDR_BITS-1:0] grant_addr,
    input  logic [DATA_BITS-1:0] grant_data,
    input  logic                 cons_read_valid,
    input  logic                 cons_write_valid,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    input  logic                 mem_write_ready,
    output channel_state_t       state,
    output logic [CW-1:0]        id,
    output logic [ADDR_BITS-1:0] addr,
    output logic [DATA_BITS-1:0] data,
    output logic                 done
);

    channel_state_t next_state;

    // Next-state logic; done pulses on the edge where the channel returns to IDLE.
    always_comb begin
        next_state = state;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (grant)
                    next_state = (grant_write && WRITE_ENABLE != 0) ? WRITE_WAIT : READ_WAIT;
            end
            READ_WAIT: begin
                if (mem_read_ready) begin
                    // A requester that abandoned its request gets no ready.
                    if (cons_read_valid) next_state = READ_RELAY;
                    else begin
                        next_state = IDLE;
                        done       = 1'b1;
                    end
                end
            end
            WRITE_WAIT: begin
                if (mem_write_ready) begin
                    if (cons_write_valid) next_state = WRITE_RELAY;
                    else begin
                        next_state = IDLE;
                        done       = 1'b1;
                    end
                end
            end
            READ_RELAY: begin
                if (!cons_read_valid) begin
                    next_state = IDLE;
                    done       = 1'b1;
                end
            end
            WRITE_RELAY: begin
                if (!cons_write_valid) begin
                    next_state = IDLE;
                    done       = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Capture request at claim; overwrite data with the memory reply on read completion.
    always_ff @(posedge clk) begin
        if (!reset) begin
            id   <= '0;
            addr <= '0;
            data <= '0;
        end else if (state == IDLE && grant) begin
            id   <= grant_id;
            addr <= grant_addr;
            data <= grant_data;
        end else if (state == READ_WAIT && mem_read_ready) begin
            data <= mem_read_data;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Multiplexes per-thread LSU requesters onto a set of memory channels with
// per-channel round-robin claim and lower-channel-first tie breaking.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 4,
    parameter int WRITE_ENABLE  = 1
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]                  mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                  mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_read_data,
    output logic [NUM_CHANNELS-1:0]                  mem_write_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_write_address,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_write_data,
    input  logic [NUM_CHANNELS-1:0]                  mem_write_ready
);

    localparam int CW = id_bits(NUM_CONSUMERS);

    channel_state_t         ch_state [NUM_CHANNELS];
    logic [CW-1:0]          ch_id    [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]   ch_addr  [NUM_CHANNELS];
    logic [DATA_BITS-1:0]   ch_data  [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] ch_done, grant, grant_write;
    logic [CW-1:0]          grant_id [NUM_CHANNELS];
    logic [CW-1:0]          rr_ptr   [NUM_CHANNELS];
    logic [CW-1:0]          scan_id;
    logic [NUM_CONSUMERS-1:0] claim_mask, grant_mask, done_mask, avail;

    // Priority-masked pick chain: each idle channel scans from its rr pointer,
    // skipping consumers already held or taken by a lower channel this cycle.
    // Scanning in reverse lets the first hit in scan order win the last assignment.
    always_comb begin
        avail      = ~claim_mask;
        grant_mask = '0;
        scan_id    = '0;
        for (int j = 0; j < NUM_CHANNELS; j++) begin
            grant[j]       = 1'b0;
            grant_write[j] = 1'b0;
            grant_id[j]    = '0;
            if (ch_state[j] == IDLE) begin
                for (int k = NUM_CONSUMERS - 1; k >= 0; k--) begin
                    scan_id = CW'((int'(rr_ptr[j]) + k) % NUM_CONSUMERS);
                    if (avail[scan_id] && (consumer_read_valid[scan_id] ||
                        (WRITE_ENABLE != 0 && consumer_write_valid[scan_id]))) begin
                        grant[j]       = 1'b1;
                        grant_id[j]    = scan_id;
                        grant_write[j] = !consumer_read_valid[scan_id];
                    end
                end
                if (grant[j]) begin
                    avail[grant_id[j]]      = 1'b0;
                    grant_mask[grant_id[j]] = 1'b1;
                end
            end
        end
    end

    // Consumers released by channels returning to IDLE this cycle.
    always_comb begin
        done_mask = '0;
        for (int j = 0; j < NUM_CHANNELS; j++)
            if (ch_done[j]) done_mask[ch_id[j]] = 1'b1;
    end

    // Claim mask and per-channel round-robin pointers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            claim_mask <= '0;
            for (int j = 0; j < NUM_CHANNELS; j++) rr_ptr[j] <= '0;
        end else begin
            claim_mask <= (claim_mask & ~done_mask) | grant_mask;
            for (int j = 0; j < NUM_CHANNELS; j++)
                if (grant[j])
                    rr_ptr[j] <= CW'((int'(grant_id[j]) + 1) % NUM_CONSUMERS);
        end
    end

    for (genvar j = 0; j < NUM_CHANNELS; j++) begin : g_ch
        logic [ADDR_BITS-1:0] g_addr;
        assign g_addr = grant_write[j] ? consumer_write_address[grant_id[j]]
                                       : consumer_read_address[grant_id[j]];

        mem_arb_channel #(
            .ADDR_BITS   (ADDR_BITS),
            .DATA_BITS   (DATA_BITS),
            .CW          (CW),
            .WRITE_ENABLE(WRITE_ENABLE)
        ) u_ch (
            .clk             (clk),
            .reset           (reset),
            .grant           (grant[j]),
            .grant_write     (grant_write[j]),
            .grant_id        (grant_id[j]),
            .grant_addr      (g_addr),
            .grant_data      (consumer_write_data[grant_id[j]]),
            .cons_read_valid (consumer_read_valid[ch_id[j]]),
            .cons_write_valid(consumer_write_valid[ch_id[j]]),
            .mem_read_ready  (mem_read_ready[j]),
            .mem_read_data   (mem_read_data[j]),
            .mem_write_ready (mem_write_ready[j]),
            .state           (ch_state[j]),
            .id              (ch_id[j]),
            .addr            (ch_addr[j]),
            .data            (ch_data[j]),
            .done            (ch_done[j])
        );
    end

    // Output mux: memory side driven only while waiting, consumer side only while relaying.
    always_comb begin
        mem_read_valid       = '0;
        mem_read_address     = '0;
        mem_write_valid      = '0;
        mem_write_address    = '0;
        mem_write_data       = '0;
        consumer_read_ready  = '0;
        consumer_read_data   = '0;
        consumer_write_ready = '0;
        for (int j = 0; j < NUM_CHANNELS; j++) begin
            if (ch_state[j] == READ_WAIT) begin
                mem_read_valid[j]   = 1'b1;
                mem_read_address[j] = ch_addr[j];
            end
            if (WRITE_ENABLE != 0 && ch_state[j] == WRITE_WAIT) begin
                mem_write_valid[j]   = 1'b1;
                mem_write_address[j] = ch_addr[j];
                mem_write_data[j]    = ch_data[j];
            end
            if (ch_state[j] == READ_RELAY) begin
                consumer_read_ready[ch_id[j]] = 1'b1;
                consumer_read_data[ch_id[j]]  = ch_data[j];
            end
            if (WRITE_ENABLE != 0 && ch_state[j] == WRITE_RELAY)
                consumer_write_ready[ch_id[j]] = 1'b1;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench: 4-channel read/write arbiter plus a 1-channel read-only instance
// used to observe round-robin alternation.
module tb_data_mem_arbiter;

    localparam int AB = 8, DB = 8, NC = 8, NCH = 4, LAT = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Main instance
    logic [NC-1:0]          rv = '0, wv = '0;
    logic [NC-1:0][AB-1:0]  raddr = '0, waddr = '0;
    logic [NC-1:0][DB-1:0]  wdata = '0;
    logic [NC-1:0]          crr, cwr;
    logic [NC-1:0][DB-1:0]  crd;
    logic [NCH-1:0]         mrv, mwv;
    logic [NCH-1:0]         mrr = '0, mwr = '0;
    logic [NCH-1:0][AB-1:0] mra, mwa;
    logic [NCH-1:0][DB-1:0] mrd = '0, mwd;

    // Single-channel read-only instance
    logic [NC-1:0]          rv1 = '0, wv1 = '0;
    logic [NC-1:0][AB-1:0]  raddr1 = '0, waddr1 = '0;
    logic [NC-1:0][DB-1:0]  wdata1 = '0;
    logic [NC-1:0]          crr1, cwr1;
    logic [NC-1:0][DB-1:0]  crd1;
    logic [0:0]             mrv1, mwv1;
    logic [0:0]             mrr1 = '0, mwr1 = '0;
    logic [0:0][AB-1:0]     mra1, mwa1;
    logic [0:0][DB-1:0]     mrd1 = '0, mwd1;

    data_mem_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC),
                       .NUM_CHANNELS(NCH), .WRITE_ENABLE(1)) dut (
        .clk(clk), .reset(reset),
        .consumer_read_valid(rv), .consumer_read_address(raddr),
        .consumer_read_ready(crr), .consumer_read_data(crd),
        .consumer_write_valid(wv), .consumer_write_address(waddr),
        .consumer_write_data(wdata), .consumer_write_ready(cwr),
        .mem_read_valid(mrv), .mem_read_address(mra),
        .mem_read_ready(mrr), .mem_read_data(mrd),
        .mem_write_valid(mwv), .mem_write_address(mwa),
        .mem_write_data(mwd), .mem_write_ready(mwr));

    data_mem_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC),
                       .NUM_CHANNELS(1), .WRITE_ENABLE(0)) dut1 (
        .clk(clk), .reset(reset),
        .consumer_read_valid(rv1), .consumer_read_address(raddr1),
        .consumer_read_ready(crr1), .consumer_read_data(crd1),
        .consumer_write_valid(wv1), .consumer_write_address(waddr1),
        .consumer_write_data(wdata1), .consumer_write_ready(cwr1),
        .mem_read_valid(mrv1), .mem_read_address(mra1),
        .mem_read_ready(mrr1), .mem_read_data(mrd1),
        .mem_write_valid(mwv1), .mem_write_address(mwa1),
        .mem_write_data(mwd1), .mem_write_ready(mwr1));

    int vecs = 0, miss = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Memory model: mem[a] = 3a+1, except 0x10 holds 0x5A.
    logic [7:0] mem [256];
    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'(a * 3 + 1);
        mem[8'h10] = 8'h5A;
    end

    // Main-instance memory: ready pulses in the LAT-th cycle of a valid, unless stalled.
    logic [NCH-1:0] stall = '0;
    int rcnt [NCH], wcnt [NCH];
    initial for (int j = 0; j < NCH; j++) begin rcnt[j] = 0; wcnt[j] = 0; end
    always @(negedge clk) begin
        for (int j = 0; j < NCH; j++) begin
            if (mrr[j]) begin mrr[j] = 1'b0; rcnt[j] = 0; end
            else if (mrv[j] && !stall[j]) begin
                rcnt[j]++;
                if (rcnt[j] >= LAT) begin mrr[j] = 1'b1; mrd[j] = mem[mra[j]]; end
            end
            if (mwr[j]) begin mwr[j] = 1'b0; wcnt[j] = 0; end
            else if (mwv[j] && !stall[j]) begin
                wcnt[j]++;
                if (wcnt[j] >= LAT) begin mwr[j] = 1'b1; mem[mwa[j]] = mwd[j]; end
            end
        end
    end

    // Read-only instance memory: one-cycle latency, data = ~address.
    always @(negedge clk) begin
        mrr1[0] = mrv1[0] && !mrr1[0];
        mrd1[0] = mra1[0] ^ 8'hFF;
    end

    logic [7:0] exp3 [8] = '{8'h81, 8'h84, 8'h87, 8'h8A, 8'h8D, 8'h90, 8'h93, 8'h96};
    logic [NC-1:0] got;
    logic [7:0] grants [4];
    int ng;
    logic prev_v, seen;

    initial begin
        // 1. Reset holds every output at 0 even with a request pending.
        reset = 1'b0;
        repeat (2) @(negedge clk);
        rv[0] = 1'b1; raddr[0] = 8'h10;
        @(negedge clk);
        chk("rst_mrv", mrv, 0);
        chk("rst_mra", mra, 0);
        chk("rst_crr", crr, 0);
        chk("rst_crd", crd, 0);
        chk("rst_mwv", mwv, 0);
        chk("rst_cwr", cwr, 0);
        chk("rst_mrv1", mrv1, 0);
        reset = 1'b1;

        // 2. Single read, memory replies in the second valid cycle.
        @(negedge clk);
        chk("rd_mrv", mrv, 4'b0001);
        chk("rd_mra0", mra[0], 8'h10);
        @(negedge clk);
        chk("rd_wait_crr", crr, 0);
        @(negedge clk);
        chk("rd_crr", crr, 8'h01);
        chk("rd_crd0", crd[0], 8'h5A);
        chk("rd_mrv_drop", mrv, 0);
        rv[0] = 1'b0;
        @(negedge clk);
        chk("rd_crr_clr", crr, 0);
        chk("rd_crd_clr", crd[0], 0);

        // Fresh pointers for the contention case.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // 3. Eight reads, four channels.
        for (int i = 0; i < NC; i++) begin rv[i] = 1'b1; raddr[i] = 8'(8'h80 + i); end
        @(negedge clk);
        chk("ct_mrv", mrv, 4'hF);
        chk("ct_mra", mra, 32'h83828180);
        chk("ct_crd_idle", crd, 0);
        got = '0;
        for (int c = 0; c < 60 && got != 8'hFF; c++) begin
            @(negedge clk);
            for (int i = 0; i < NC; i++)
                if (crr[i]) begin
                    chk($sformatf("ct_data%0d", i), crd[i], exp3[i]);
                    rv[i] = 1'b0;
                    got[i] = 1'b1;
                end
        end
        chk("ct_all_served", got, 8'hFF);
        @(negedge clk);
        chk("ct_quiet", crr, 0);

        // 5. Write c2: 0xA5 -> 0x20.
        wv[2] = 1'b1; waddr[2] = 8'h20; wdata[2] = 8'hA5;
        @(negedge clk);
        chk("wr_mwv", mwv, 4'b0001);
        chk("wr_mwa0", mwa[0], 8'h20);
        chk("wr_mwd0", mwd[0], 8'hA5);
        chk("wr_mrv", mrv, 0);
        @(negedge clk);
        chk("wr_wait_cwr", cwr, 0);
        @(negedge clk);
        chk("wr_cwr", cwr, 8'h04);
        chk("wr_mem", mem[8'h20], 8'hA5);
        chk("wr_mwv_drop", mwv, 0);
        wv[2] = 1'b0;
        @(negedge clk);
        chk("wr_cwr_clr", cwr, 0);

        // 6. Reset while in READ_WAIT, then the held request completes.
        stall = '1;
        rv[5] = 1'b1; raddr[5] = 8'h33;
        @(negedge clk);
        chk("mr_mrv", mrv, 4'b0001);
        chk("mr_mra0", mra[0], 8'h33);
        reset = 1'b0;
        @(negedge clk);
        chk("mr_rst_mrv", mrv, 0);
        chk("mr_rst_crr", crr, 0);
        reset = 1'b1;
        stall = '0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (crr[5]) begin
                seen = 1'b1;
                chk("mr_crd5", crd[5], 8'h9A);
                rv[5] = 1'b0;
            end
        end
        chk("mr_done", seen, 1'b1);

        // 4. Round-robin on the single channel: c1 and c6 re-request continuously.
        raddr1[1] = 8'h41; raddr1[6] = 8'h46;
        ng = 0; prev_v = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (mrv1[0] && !prev_v) begin
                if (ng < 4) grants[ng] = mra1[0];
                ng++;
            end
            prev_v = mrv1[0];
            if (crr1[1]) begin chk("rr_crd1", crd1[1], 8'hBE); rv1[1] = 1'b0; end
            else rv1[1] = 1'b1;
            if (crr1[6]) begin chk("rr_crd6", crd1[6], 8'hB9); rv1[6] = 1'b0; end
            else rv1[6] = 1'b1;
        end
        chk("rr_count", 64'(ng >= 4), 1);
        chk("rr_g0", grants[0], 8'h41);
        chk("rr_g1", grants[1], 8'h46);
        chk("rr_g2", grants[2], 8'h41);
        chk("rr_g3", grants[3], 8'h46);
        chk("ro_cwr1", cwr1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
